// File: rtl/and_gate_pkg.sv
// -----------------------------------------------------------------------------
// and_gate_pkg
//   Shared definitions for the branch-decision gate and its statistics
//   counters.
//   CNT_W_DEF : default width of each statistics counter
//   br_cnt_t  : counter value type at the default width
// -----------------------------------------------------------------------------
package and_gate_pkg;

   localparam int unsigned CNT_W_DEF = 16;

   typedef logic [CNT_W_DEF-1:0] br_cnt_t;

endpackage : and_gate_pkg

// File: rtl/and_gate_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter. It sticks at all-ones and never wraps. A clear
//   takes priority over a simultaneous increment.
//   Ports:
//     clk  in   1  rising-edge clock
//     rst  in   1  asynchronous active-high reset (q -> 0)
//     clr  in   1  synchronous clear (q -> 0)
//     inc  in   1  count enable for this edge
//     q    out  W  current count
// -----------------------------------------------------------------------------
module sat_counter
   import and_gate_pkg::*;
#(
   parameter int unsigned W = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule : sat_counter

// File: rtl/and_gate.sv
// -----------------------------------------------------------------------------
// and_gate
//   Branch-decision gate for the single-cycle RISC-V datapath. The ALU zero
//   flag is ANDed with the branch signal from the control unit. The result
//   drives the PC-source select: 1 takes the branch target, 0 selects PC+4.
//   The gate also provides a registered copy of the decision and, as an
//   option, branch and taken statistics counters for debug.
//
//   Build option: define AND_GATE_STATS_EN to instantiate the counters.
//   When the macro is not defined, branch_cnt and taken_cnt are tied to zero
//   and cnt_clr is ignored.
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous active-high reset
//     zero       in   1      ALU zero flag
//     branch     in   1      branch instruction decoded
//     cnt_clr    in   1      synchronous clear of the statistics counters
//     and_out    out  1      zero & branch, combinational
//     and_out_q  out  1      and_out registered on clk
//     branch_cnt out  CNT_W  edges with branch=1 (saturating)
//     taken_cnt  out  CNT_W  edges with and_out=1 (saturating)
// -----------------------------------------------------------------------------
module and_gate
   import and_gate_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             zero,
   input  logic             branch,
   input  logic             cnt_clr,
   output logic             and_out,
   output logic             and_out_q,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   // Same-cycle PC-source select. rst does not affect this path.
   assign and_out = zero & branch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         and_out_q <= 1'b0;
      end else begin
         and_out_q <= and_out;
      end
   end

`ifdef AND_GATE_STATS_EN
   sat_counter #(
      .W (CNT_W)
   ) u_branch_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (branch),
      .q   (branch_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_taken_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (and_out),
      .q   (taken_cnt)
   );
`else
   // The counters are not built, so cnt_clr has no load.
   logic stats_unused;
   assign stats_unused = cnt_clr;

   assign branch_cnt = '0;
   assign taken_cnt  = '0;
`endif

endmodule : and_gate

// File: tb/tb_and_gate.sv
// -----------------------------------------------------------------------------
// tb_and_gate
//   Self-checking bench for and_gate. It drives two instances from the same
//   inputs: one at the default counter width and one at CNT_W=2, which shows
//   saturation after a few edges. Expected counter values come from
//   integer counts capped at 2^W-1. When AND_GATE_STATS_EN is not defined,
//   the expected counter values are zero.
// -----------------------------------------------------------------------------
module tb_and_gate;
   import and_gate_pkg::*;

`ifdef AND_GATE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam int MAX1 = 65535;
   localparam int MAX2 = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        zero;
   logic        branch;
   logic        cnt_clr;
   logic        and_out, and_out_q, and_out2, and_out_q2;
   logic [15:0] branch_cnt, taken_cnt;
   logic [1:0]  branch_cnt2, taken_cnt2;

   int checks   = 0;
   int failures = 0;

   // Model state: decision counts and the previous-cycle decision.
   int   m_br, m_tk, m_br2, m_tk2;
   logic m_q;

   always #5 clk = ~clk;

   and_gate #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .zero(zero), .branch(branch), .cnt_clr(cnt_clr),
      .and_out(and_out), .and_out_q(and_out_q),
      .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   and_gate #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .zero(zero), .branch(branch), .cnt_clr(cnt_clr),
      .and_out(and_out2), .and_out_q(and_out_q2),
      .branch_cnt(branch_cnt2), .taken_cnt(taken_cnt2)
   );

   typedef struct {
      logic z;
      logic b;
      logic exp;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v, input int max);
      return (v < max) ? v + 1 : v;
   endfunction

   task automatic model_clear();
      m_br = 0; m_tk = 0; m_br2 = 0; m_tk2 = 0; m_q = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".and_out_q"},   and_out_q,   m_q);
      chk({tag, ".and_out_q2"},  and_out_q2,  m_q);
      chk({tag, ".branch_cnt"},  branch_cnt,  STATS ? m_br  : 0);
      chk({tag, ".taken_cnt"},   taken_cnt,   STATS ? m_tk  : 0);
      chk({tag, ".branch_cnt2"}, branch_cnt2, STATS ? m_br2 : 0);
      chk({tag, ".taken_cnt2"},  taken_cnt2,  STATS ? m_tk2 : 0);
   endtask

   // Drive one cycle of inputs mid-cycle, check the combinational output,
   // advance one rising edge, then check the registered outputs.
   task automatic apply(input logic z, input logic b, input logic c, input string tag);
      zero = z; branch = b; cnt_clr = c;
      #1;
      chk({tag, ".and_out"},  and_out,  z & b);
      chk({tag, ".and_out2"}, and_out2, z & b);
      if (c) begin
         m_br = 0; m_tk = 0; m_br2 = 0; m_tk2 = 0;
      end else begin
         if (b)     begin m_br = sat_inc(m_br, MAX1); m_br2 = sat_inc(m_br2, MAX2); end
         if (z & b) begin m_tk = sat_inc(m_tk, MAX1); m_tk2 = sat_inc(m_tk2, MAX2); end
      end
      m_q = z & b;
      @(posedge clk);
      #1;
      check_regs(tag);
   endtask

   // Pulse rst between edges, then release it after one edge so the edge
   // sees rst asserted. Call this while mid-cycle.
   task automatic pulse_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      check_regs({tag, ".imm"});
      @(posedge clk);
      #1;
      check_regs({tag, ".hold"});
      rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'bx, 1'b0};
      vecs[5] = '{1'bx, 1'b0, 1'b0};

      rst = 1'b1; zero = 1'b0; branch = 1'b0; cnt_clr = 1'b0;
      model_clear();
      #1;
      check_regs("reset");
      chk("reset.and_out", and_out, 0);
      #11 rst = 1'b0;

      // Truth table (and the X cases) applied with rst held, so and_out is
      // shown to be independent of reset.
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         zero = vecs[i].z; branch = vecs[i].b;
         #1;
         checks++;
         if (and_out !== vecs[i].exp) begin
            failures++;
            $display("FAIL tt[%0d].and_out: got %b expected %b", i, and_out, vecs[i].exp);
         end
         chk($sformatf("tt[%0d].and_out_q_rst", i), and_out_q, 0);
      end
      zero = 1'b0; branch = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Five branch edges, taken on three of them.
      apply(1, 1, 0, "seq5.0");
      apply(0, 1, 0, "seq5.1");
      apply(1, 1, 0, "seq5.2");
      apply(0, 1, 0, "seq5.3");
      apply(1, 1, 0, "seq5.4");
      chk("seq5.branch_cnt", branch_cnt, STATS ? 5 : 0);
      chk("seq5.taken_cnt",  taken_cnt,  STATS ? 3 : 0);

      // Saturation of the 2-bit instance.
      pulse_reset("sat_rst");
      for (int i = 0; i < 6; i++) apply(1, 1, 0, "sat");
      chk("sat.branch_cnt2", branch_cnt2, STATS ? 3 : 0);
      chk("sat.taken_cnt2",  taken_cnt2,  STATS ? 3 : 0);
      chk("sat.branch_cnt",  branch_cnt,  STATS ? 6 : 0);

      // Clear takes priority over an increment on the same edge.
      apply(1, 1, 1, "clr");
      chk("clr.branch_cnt", branch_cnt, 0);
      chk("clr.taken_cnt",  taken_cnt,  0);
      apply(1, 1, 0, "clr_after");

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         apply(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), "rand");
      end

      // Reset in the middle of a cycle with nonzero counters. The registers
      // drop at once, and_out still follows its inputs, and counting resumes
      // on the first edge after release.
      apply(1, 1, 0, "pre_rst");
      zero = 1'b1; branch = 1'b1;
      pulse_reset("mid_rst");
      chk("mid_rst.and_out", and_out, 1);
      apply(1, 1, 0, "post_rst");
      chk("post_rst.branch_cnt", branch_cnt, STATS ? 1 : 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a hang.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_and_gate
